cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Parametrised common data bus (CDB) arbiter for the Tomasulo back end. Each functional unit (add/mul reservation-station execution paths) deposits a completed result `{tag, data}` into a per-channel one-entry holding buffer via a valid/ready handshake. A round-robin arbiter selects one full buffer per cycle and broadcasts it on the registered CDB to the FLR and all reservation stations. It generalises the fixed two-unit tag/data crossing to N channels with fair arbitration and back-pressure.

## Interface
Parameters:
- `NUM_FU`, 4, number of functional-unit channels (2..16)
- `TAG_W`, 5, rename tag width
- `DATA_W`, 32, result data width
- `SRC_W`, `$clog2(NUM_FU)`, channel index width (derived, not overridden)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_FU  per-channel result valid
- `req_tag`  in  NUM_FU*TAG_W  per-channel tag; channel i occupies bits [i*TAG_W +: TAG_W]
- `req_data`  in  NUM_FU*DATA_W  per-channel data, same packing
- `req_ready`  out  NUM_FU  per-channel buffer can accept
- `cdb_valid`  out  1  broadcast valid this cycle
- `cdb_tag`  out  TAG_W  broadcast tag
- `cdb_data`  out  DATA_W  broadcast data
- `cdb_src`  out  SRC_W  channel index that won
- `flush`  in  1  present only with `CDB_FLUSH_EN`

## Operation
- Per channel: holding buffer `{full, tag, data}`.
- Handshake: a transfer occurs on an edge where `req_valid[i] & req_ready[i]` is high.
- `req_ready[i] = !full[i] | grant[i]`. This is combinational, so the buffer accepts a new result in the same edge that drains it. No combinational path from `req_valid` to `req_ready`.
- Arbitration (combinational): round-robin over the `full` vector. Search starts at pointer `rr_ptr` and proceeds ascending with wrap `NUM_FU-1 -> 0`. At most one grant per cycle.
- On each edge with a grant to channel g:
  - `full[g]` clears unless it is refilled the same edge.
  - `cdb_valid <= 1`, `cdb_tag/data <= buffer[g]`, `cdb_src <= g`.
  - `rr_ptr <= (g+1) mod NUM_FU`.
- On each edge with no grant: `cdb_valid <= 0`. `cdb_tag/data/src` hold their previous values, and `rr_ptr` holds.
- Data in the buffers and on the CDB is never modified. Tags are not checked for duplicates.

## Timing
- Reset (rst=0, asynchronous): all `full=0`, `rr_ptr=0`, `cdb_valid=0`, `cdb_tag=0`, `cdb_data=0`, `cdb_src=0`. `req_ready` reads all-ones while in reset.
- Latency: handshake at edge E0 gives `cdb_valid` high after E1 if uncontended. Each further contending full buffer adds 1 cycle.
- Throughput: 1 broadcast/cycle. Worst-case wait for a full buffer is NUM_FU-1 grants.
- All channels full and all valid: each channel is granted once per NUM_FU cycles. A channel stays ready only on its grant cycle.
- Single requester streaming: that channel is granted every cycle, holds `req_ready=1`, and gets back-to-back `cdb_valid`.
- Reset asserted mid-operation: buffered results are discarded, and `cdb_valid` drops immediately (asynchronously).
- `rst` deassertion is synchronised externally. The first handshake is allowed on the first rising edge after release.

## Configuration
- `CDB_FLUSH_EN` defined:
  - The `flush` port exists.
  - An edge with `flush=1` clears all `full`, forces `cdb_valid <= 0` and holds `rr_ptr`.
  - `req_ready` is all-zeros while `flush=1`, so no handshake occurs.
  - Flush takes priority over any grant in that cycle.
- Not defined: the `flush` port is absent and buffers drain only via grants.

## Test plan
- Reset then idle:
  - During reset: `cdb_valid=0`, `cdb_tag=0`, `cdb_data=0`, `req_ready=4'b1111`.
  - After release with no requests: `cdb_valid` stays 0.
- Single transfer: ch2 sends tag 5'd7, data 32'hDEADBEEF at E0.
  - After E1: `cdb_valid=1`, `cdb_tag=7`, `cdb_data=DEADBEEF`, `cdb_src=2`.
  - After E2: `cdb_valid=0`.
- Full contention: all 4 channels hold valid continuously from reset with distinct tags 1..4.
  - Broadcast order is src 0,1,2,3,0,...
  - Each `req_ready[i]` is high only on its grant cycle.
- Same-edge refill: ch1 streams tags 10,11,12 on consecutive cycles, all others idle.
  - Three consecutive `cdb_valid` cycles with tags 10,11,12.
  - `req_ready[1]` stays 1 throughout.
- Pointer wrap: with `rr_ptr` at 3 (after a grant to ch2), ch0 and ch3 become full together.
  - ch3 is granted first, then ch0.
- Flush (`CDB_FLUSH_EN`): ch0 and ch1 full, `flush=1` for one edge.
  - `cdb_valid=0` next cycle, both buffers empty.
  - `req_ready=0` during flush.
  - With no new requests, nothing is broadcast afterward.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common data bus arbiter over per-channel one-entry result buffers
// Ports: clk; rst (asynchronous, active-low); req_valid/req_tag/req_data in and req_ready out per channel;
//        cdb_valid/cdb_tag/cdb_data/cdb_src registered broadcast; flush input only when CDB_FLUSH_EN is defined.
// Macro CDB_FLUSH_EN: adds flush, which empties every buffer and suppresses the broadcast for that edge.
module cdb_arbiter #(
    parameter  int NUM_FU = 4,
    parameter  int TAG_W  = 5,
    parameter  int DATA_W = 32,
    localparam int SRC_W  = $clog2(NUM_FU)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        req_valid,
    input  logic [NUM_FU*TAG_W-1:0]  req_tag,
    input  logic [NUM_FU*DATA_W-1:0] req_data,
    output logic [NUM_FU-1:0]        req_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [SRC_W-1:0]         cdb_src
`ifdef CDB_FLUSH_EN
    ,
    input  logic                     flush
`endif
);
    logic fl;
`ifdef CDB_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif
    logic [NUM_FU-1:0] full, grant, xfer;
    logic [TAG_W-1:0]  buf_tag  [NUM_FU];
    logic [DATA_W-1:0] buf_data [NUM_FU];
    logic [SRC_W-1:0]  rr_ptr, gnt_idx, cand;
    logic              found;
    // first full buffer at or after rr_ptr, wrapping at NUM_FU
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % NUM_FU);
            if (!found && full[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end
    assign grant     = found ? (NUM_FU'(1) << gnt_idx) : '0;
    assign req_ready = fl ? '0 : (~full | grant);
    assign xfer      = req_valid & req_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full      <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                buf_tag[i]  <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            cdb_valid <= found && !fl;
            if (found && !fl) begin
                cdb_tag  <= buf_tag[gnt_idx];
                cdb_data <= buf_data[gnt_idx];
                cdb_src  <= gnt_idx;
                rr_ptr   <= (gnt_idx == SRC_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (fl) begin
                    full[i] <= 1'b0;
                end else if (xfer[i]) begin
                    full[i]     <= 1'b1;
                    buf_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                    buf_data[i] <= req_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a behavioural buffer/round-robin model
module tb_cdb_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [19:0]  req_tag = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;
    logic         flush = 1'b0;
    int checks = 0;
    int errors = 0;
    bit          m_full [4];
    logic [4:0]  m_tag  [4];
    logic [31:0] m_data [4];
    int          m_ptr;
    logic        m_v;
    logic [4:0]  m_ctag;
    logic [31:0] m_cdata;
    int          m_src;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_src(cdb_src)
`ifdef CDB_FLUSH_EN
        , .flush(flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 0;
            m_tag[i]  = '0;
            m_data[i] = '0;
        end
        m_ptr = 0; m_v = 0; m_ctag = '0; m_cdata = '0; m_src = 0;
    endfunction

    task automatic set_ch(input int i, input bit v, input logic [4:0] t, input logic [31:0] d);
        req_valid[i]         = v;
        req_tag[i*5 +: 5]    = t;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic tick();
        int g;
        logic [3:0] exp_rdy;
        #2;
        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && m_full[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        for (int i = 0; i < 4; i++) exp_rdy[i] = !flush && (!m_full[i] || g == i);
        chk("ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        if (flush) begin
            for (int i = 0; i < 4; i++) m_full[i] = 0;
            m_v = 0;
        end else begin
            m_v = (g >= 0);
            if (g >= 0) begin
                m_ctag = m_tag[g]; m_cdata = m_data[g]; m_src = g;
                m_ptr = (g + 1) % 4;
                m_full[g] = 0;
            end
            for (int i = 0; i < 4; i++)
                if (req_valid[i] && exp_rdy[i]) begin
                    m_full[i] = 1;
                    m_tag[i]  = req_tag[i*5 +: 5];
                    m_data[i] = req_data[i*32 +: 32];
                end
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_v});
        chk("cdb_tag", {59'd0, cdb_tag}, {59'd0, m_ctag});
        chk("cdb_data", {32'd0, cdb_data}, {32'd0, m_cdata});
        chk("cdb_src", {62'd0, cdb_src}, 64'(m_src));
    endtask

    initial begin
        m_reset();
        #3;
        chk("rst_valid", {63'd0, cdb_valid}, 64'd0);
        chk("rst_tag", {59'd0, cdb_tag}, 64'd0);
        chk("rst_data", {32'd0, cdb_data}, 64'd0);
        chk("rst_ready", {60'd0, req_ready}, 64'hf);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_valid", {63'd0, cdb_valid}, 64'd0);
        // single transfer on ch2
        set_ch(2, 1, 5'd7, 32'hDEADBEEF);
        tick();
        set_ch(2, 0, 5'd0, 32'd0);
        tick();
        chk("single_valid", {63'd0, cdb_valid}, 64'd1);
        chk("single_tag", {59'd0, cdb_tag}, 64'd7);
        chk("single_data", {32'd0, cdb_data}, 64'hDEADBEEF);
        chk("single_src", {62'd0, cdb_src}, 64'd2);
        tick();
        chk("single_drop", {63'd0, cdb_valid}, 64'd0);
        // pointer wrap: pointer sits at 3, ch0 and ch3 fill together
        set_ch(0, 1, 5'd20, 32'h20);
        set_ch(3, 1, 5'd23, 32'h23);
        tick();
        set_ch(0, 0, 5'd0, 32'd0);
        set_ch(3, 0, 5'd0, 32'd0);
        tick();
        chk("wrap_first", {62'd0, cdb_src}, 64'd3);
        tick();
        chk("wrap_second", {62'd0, cdb_src}, 64'd0);
        chk("wrap_tag", {59'd0, cdb_tag}, 64'd20);
        // same-edge refill on ch1
        for (int t = 0; t < 5; t++) begin
            if (t < 3) set_ch(1, 1, 5'(10 + t), 32'(100 + t));
            else set_ch(1, 0, 5'd0, 32'd0);
            #1;
            if (t < 3) chk("refill_ready", {63'd0, req_ready[1]}, 64'd1);
            tick();
            if (t >= 1 && t <= 3) begin
                chk("refill_valid", {63'd0, cdb_valid}, 64'd1);
                chk("refill_tag", {59'd0, cdb_tag}, 64'(9 + t));
            end
        end
        chk("refill_end", {63'd0, cdb_valid}, 64'd0);
        // asynchronous reset mid-operation
        set_ch(0, 1, 5'd3, 32'h3);
        set_ch(1, 1, 5'd4, 32'h4);
        tick();
        req_valid = '0;
        tick();
        chk("pre_rst_valid", {63'd0, cdb_valid}, 64'd1);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, cdb_valid}, 64'd0);
        chk("async_rst_ready", {60'd0, req_ready}, 64'hf);
        m_reset();
        // full contention held from reset
        for (int i = 0; i < 4; i++) set_ch(i, 1, 5'(i + 1), 32'hA000 + 32'(i));
        @(posedge clk); #1;
        rst = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            #2;
            if (t >= 2) chk("cont_ready", {60'd0, req_ready}, 64'(1 << ((t - 2) % 4)));
            tick();
            if (t >= 2) chk("cont_src", {62'd0, cdb_src}, 64'((t - 2) % 4));
        end
        req_valid = '0;
        repeat (6) tick();
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) set_ch(i, 1'($urandom), 5'($urandom), $urandom);
`ifdef CDB_FLUSH_EN
            flush = ($urandom_range(15) == 0);
`endif
            tick();
        end
        flush = 1'b0;
        req_valid = '0;
        repeat (6) tick();
`ifdef CDB_FLUSH_EN
        set_ch(0, 1, 5'd1, 32'h1);
        set_ch(1, 1, 5'd2, 32'h2);
        tick();
        req_valid = '0;
        flush = 1'b1;
        #1;
        chk("flush_ready", {60'd0, req_ready}, 64'd0);
        tick();
        chk("flush_valid", {63'd0, cdb_valid}, 64'd0);
        flush = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("post_flush_valid", {63'd0, cdb_valid}, 64'd0);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
